// File: rtl/packet_commit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : packet_commit_fifo
// Purpose  : Whole-packet store-and-forward buffer. Beats from an Avalon-ST
//            source without backpressure are written speculatively and are
//            published to the output side only after the packet's eop beat
//            is stored. Truncated, malformed or oversized packets are rolled
//            back and dropped. The output is an Avalon-ST source with
//            backpressure, driven from a first-word-fall-through register.
//
// Ports    : clock, reset                  single clock, sync active-high reset
//            in_data/in_valid/in_startofpacket/in_endofpacket/in_empty
//                                          input stream, no ready
//            out_data/out_valid/out_ready/out_startofpacket/out_endofpacket/
//            out_empty                     output stream with backpressure
//            drop_count                    saturating dropped-packet count
//            frame_err                     one-cycle framing-violation pulse
//
// Build    : PACKET_COMMIT_FIFO_STATS_EN defined   -> drop_count/frame_err live
//            PACKET_COMMIT_FIFO_STATS_EN undefined -> both tied to zero
//
// Revision : 1.0  initial release
// ============================================================================
module packet_commit_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 32,
    parameter int EMPTY_W    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [15:0]        drop_count,
    output logic               frame_err
);

    localparam int c_PTR_W   = DEPTH_LOG2 + 1;
    localparam int c_ENTRY_W = EMPTY_W + 2 + DATA_W;
    localparam int c_DEPTH   = 1 << DEPTH_LOG2;

    localparam logic [c_PTR_W-1:0] c_FULL = c_PTR_W'(c_DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RECV    = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [0:c_DEPTH-1];

    logic [c_PTR_W-1:0] r_wr_ptr;      // speculative write pointer
    logic [c_PTR_W-1:0] r_commit_ptr;  // end of last complete packet
    logic [c_PTR_W-1:0] r_commit_vis;  // commit pointer as seen by read side
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [1:0]         r_state;

    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_sop;
    logic               r_out_eop;
    logic [EMPTY_W-1:0] r_out_empty;

    // ------------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------------
    // An sop arriving mid-packet restarts at commit_ptr, so the space check
    // must be made against that rolled-back position, not the stale wr_ptr.
    logic               w_restart;
    logic [c_PTR_W-1:0] w_base;
    logic [c_PTR_W-1:0] w_base_used;
    logic               w_space;

    assign w_restart   = in_valid && in_startofpacket && (r_state == c_ST_RECV);
    assign w_base      = w_restart ? r_commit_ptr : r_wr_ptr;
    assign w_base_used = w_base - r_rd_ptr;
    assign w_space     = (w_base_used != c_FULL);

    logic [1:0]         w_state_nxt;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_commit_ptr_nxt;
    logic               w_mem_we;
    logic [c_PTR_W-1:0] w_mem_waddr;
    logic               w_start;
    logic [1:0]         w_drop_inc;
    logic               w_frame_err;

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_mem_we         = 1'b0;
        w_mem_waddr      = w_base;
        w_start          = 1'b0;
        w_drop_inc       = 2'd0;
        w_frame_err      = 1'b0;

        if (in_valid) begin
            case (r_state)
                c_ST_RECV: begin
                    if (in_startofpacket) begin
                        // Abandon the open packet, then treat this beat as a
                        // fresh start at the committed boundary.
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_drop_inc   = 2'd1;
                        w_frame_err  = 1'b1;
                        w_start      = 1'b1;
                    end else if (w_space) begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        if (in_endofpacket) begin
                            w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                            w_state_nxt      = c_ST_IDLE;
                        end
                    end else begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_drop_inc   = 2'd1;
                        w_state_nxt  = in_endofpacket ? c_ST_IDLE : c_ST_DISCARD;
                    end
                end
                c_ST_DISCARD: begin
                    if (in_startofpacket) begin
                        w_frame_err = 1'b1;
                        w_start     = 1'b1;
                    end else if (in_endofpacket) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    if (in_startofpacket) begin
                        w_start = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            endcase

            if (w_start) begin
                if (w_space) begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = w_base + 1'b1;
                    if (in_endofpacket) begin
                        w_commit_ptr_nxt = w_base + 1'b1;
                        w_state_nxt      = c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_RECV;
                    end
                end else begin
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = in_endofpacket ? c_ST_IDLE : c_ST_DISCARD;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr[DEPTH_LOG2-1:0]] <=
                {in_empty, in_endofpacket, in_startofpacket, in_data};
        end
    end

    // commit_ptr is re-registered before the read side sees it, giving the
    // fixed two-cycle eop-to-out_valid latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_commit_vis <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_commit_vis <= r_commit_ptr;
        end
    end

    // ------------------------------------------------------------------------
    // Read side: first-word-fall-through output register
    // ------------------------------------------------------------------------
    logic                 w_load;
    logic [c_ENTRY_W-1:0] w_rd_entry;

    assign w_rd_entry = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign w_load     = (r_rd_ptr != r_commit_vis) && (!r_out_valid || out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
        end else if (w_load) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_entry[DATA_W-1:0];
            r_out_sop   <= w_rd_entry[DATA_W];
            r_out_eop   <= w_rd_entry[DATA_W+1];
            r_out_empty <= w_rd_entry[c_ENTRY_W-1 -: EMPTY_W];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data          = r_out_data;
    assign out_valid         = r_out_valid;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef PACKET_COMMIT_FIFO_STATS_EN
    logic [15:0] r_drop_count;
    logic        r_frame_err;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + {15'd0, w_drop_inc};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_count <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_frame_err  <= w_frame_err;
        end
    end

    assign drop_count = r_drop_count;
    assign frame_err  = r_frame_err;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{w_drop_inc, w_frame_err};
    assign drop_count     = '0;
    assign frame_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/packet_commit_fifo.md
# packet_commit_fifo

Whole-packet store-and-forward buffer that consumes the Avalon-ST stream produced by the FPGA-to-HPS input FIFO (32-bit data, sop/eop/empty, valid, no ready). Beats are written speculatively and become visible to the downstream stage only once the packet's eop beat is stored. Truncated, malformed or oversized packets are rolled back and dropped. The output is an Avalon-ST source with backpressure, feeding the packet processing pipeline.

## Interface
- DEPTH_LOG2, 6, storage depth is 2**DEPTH_LOG2 words (64)
- DATA_W, 32, data width
- EMPTY_W, 2, width of the empty field
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  DATA_W  input beat data
- in_valid  in  1  beat present; no ready, every valid beat must be consumed
- in_startofpacket  in  1  first beat of packet
- in_endofpacket  in  1  last beat of packet
- in_empty  in  EMPTY_W  unused bytes in eop beat
- out_data  out  DATA_W  output beat data
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts beat
- out_startofpacket / out_endofpacket  out  1 each  framing
- out_empty  out  EMPTY_W  empty field
- drop_count  out  16  saturating count of dropped packets (stats build only)
- frame_err  out  1  one-cycle pulse on framing violation (stats build only)

## Operation
- Memory entry = {empty, eop, sop, data}. Pointers wr_ptr (speculative), commit_ptr, rd_ptr, each DEPTH_LOG2+1 bits, wrap naturally modulo 2**(DEPTH_LOG2+1).
- Free space = 2**DEPTH_LOG2 - (wr_ptr - rd_ptr), computed from registered rd_ptr; a read in the same cycle frees space only from the next cycle.
- Write FSM states IDLE, RECV, DISCARD:
  - IDLE: sop beat with space -> write, wr_ptr+1; if also eop -> commit_ptr <= wr_ptr+1, stay IDLE, else -> RECV. sop beat without space -> drop, -> DISCARD (IDLE if also eop). Non-sop beat -> ignored, frame_err.
  - RECV: non-sop beat with space -> write; eop -> commit, -> IDLE. Non-sop beat without space -> wr_ptr <= commit_ptr, drop_count+1, -> DISCARD (IDLE if eop). sop beat -> abort current packet (wr_ptr <= commit_ptr, drop_count+1, frame_err) and restart it as new packet written at commit_ptr, per IDLE rules.
  - DISCARD: beats ignored; eop -> IDLE; sop beat -> frame_err, handled per IDLE rules.
- Dropping in IDLE for lack of space also increments drop_count.
- Packets longer than 2**DEPTH_LOG2 beats are always dropped.
- Read side: first-word-fall-through output register; loads from memory whenever rd_ptr != commit_ptr and register empty or being consumed (out_valid & out_ready).
- Rollback never touches rd_ptr or the output register.

## Timing
- Reset values: out_valid 0, out_data 0, out_startofpacket 0, out_endofpacket 0, out_empty 0, drop_count 0, frame_err 0, all pointers 0, FSM IDLE.
- Input beat sampled on the edge where in_valid=1; memory write on that edge.
- Commit latency: with output idle, out_valid rises exactly 2 cycles after the edge sampling the eop beat.
- Throughput: one beat per cycle in and out, sustained, with out_ready held high.
- out_* stable while out_valid & !out_ready.
- reset mid-packet: all state cleared; uncommitted and committed data discarded; drop_count not incremented.
- drop_count saturates at 0xFFFF.

## Configuration
- PACKET_COMMIT_FIFO_STATS_EN defined: drop_count and frame_err implemented as above.
- Not defined: counter and pulse logic omitted; drop_count tied to 0, frame_err tied to 0; datapath behaviour identical.

## Test plan
- 4-beat packet (sop on beat 0, eop+empty=2 on beat 3), out_ready=1 -> out_valid rises 2 cycles after eop edge, 4 beats out in order, out_empty=2 on last, drop_count 0.
- DEPTH 64: 65-beat packet then 3-beat packet -> first dropped, drop_count=1, only 3-beat packet emitted.
- sop, 2 beats, then new sop without eop, new packet 2 beats with eop -> frame_err one pulse, drop_count=1, only second packet output.
- Orphan non-sop beat in IDLE -> frame_err pulse, nothing stored, drop_count unchanged.
- out_ready=0 while eight 8-beat packets arrive (fills 64 words), ninth packet -> dropped, drop_count=1; then out_ready=1 -> 64 beats out unchanged.
- Reset asserted mid-packet after 2 beats, then clean 1-beat sop+eop packet -> only that packet emitted, drop_count 0.
